// File: rtl/fp8_accumulator.sv
// rtl/fp8_accumulator.sv - sums N_TERMS fp8 minifloat terms exactly, then rounds to one fp8 result
// Format: [7] sign, [6:4] exponent (bias 3), [3:0] mantissa; accumulator LSB is 2^-6.
module fp8_accumulator #(
   parameter int N_TERMS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] input_a,
   input  logic       input_a_stb,
   output logic       input_ready,
   output logic [7:0] output_z,
   output logic       output_z_stb
);
   localparam int ACC_W = 11 + $clog2(N_TERMS);
   localparam int CNT_W = $clog2(N_TERMS + 1);
   localparam int EXP_W = $clog2(ACC_W) + 2;

   typedef enum logic [2:0] {
      S_ACCUM, S_LOAD, S_SHIFT, S_ROUND, S_PACK, S_PUT, S_CLEAR
   } state_t;

   state_t             r_state, w_next;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_nan, r_pinf, r_ninf;
   logic [ACC_W-1:0]   r_mag;
   logic               r_zs, r_guard, r_sticky;
   logic [EXP_W-1:0]   r_exp;
   logic [7:0]         r_z;
   logic [7:0]         r_out_z;
   logic               r_out_stb;

   logic [2:0]         w_e;
   logic [3:0]         w_m;
   logic [ACC_W-1:0]   w_mag, w_term;
   logic               w_nan, w_pinf, w_ninf;
   logic               w_rup;
   logic [5:0]         w_rnd;
   logic [EXP_W-1:0]   w_exp_n;
   logic [7:0]         w_pack;

   assign w_e = input_a[6:4];
   assign w_m = input_a[3:0];

   // Term decode into signed fixed point; infinities contribute zero magnitude and only set flags.
   always_comb begin
      w_mag  = '0;
      w_nan  = 1'b0;
      w_pinf = 1'b0;
      w_ninf = 1'b0;
      if (w_e == 3'd0) begin
         w_mag = ACC_W'(w_m);
      end else if (w_e == 3'd7) begin
         if (w_m != 4'd0) w_nan = 1'b1;
         else if (input_a[7]) w_ninf = 1'b1;
         else w_pinf = 1'b1;
      end else begin
         w_mag = ACC_W'({1'b1, w_m}) << (w_e - 3'd1);
      end
      w_term = input_a[7] ? (~w_mag + 1'b1) : w_mag;
   end

   assign w_rup   = r_guard & (r_sticky | r_mag[0]);
   assign w_rnd   = {1'b0, r_mag[4:0]} + {5'd0, w_rup};
   assign w_exp_n = r_exp + {{(EXP_W-1){1'b0}}, r_mag[4]};

   always_comb begin
      w_pack = {r_zs, r_exp[2:0], r_mag[3:0]};
      if (r_nan || (r_pinf && r_ninf)) w_pack = 8'hF8;
      else if (r_pinf)                 w_pack = 8'h70;
      else if (r_ninf)                 w_pack = 8'hF0;
      else if (r_acc == '0)            w_pack = 8'h00;
      else if (r_exp >= EXP_W'(7))     w_pack = {r_zs, 7'h70};
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_ACCUM;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      input_ready = 1'b0;
      case (r_state)
         S_ACCUM: begin
            input_ready = 1'b1;
            if (input_a_stb && (r_cnt == CNT_W'(N_TERMS - 1))) w_next = S_LOAD;
         end
         S_LOAD:  w_next = S_SHIFT;
         S_SHIFT: if (r_mag < ACC_W'(32)) w_next = S_ROUND;
         S_ROUND: w_next = S_PACK;
         S_PACK:  w_next = S_PUT;
         S_PUT:   w_next = S_CLEAR;
         S_CLEAR: w_next = S_ACCUM;
         default: w_next = S_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_nan     <= 1'b0;
         r_pinf    <= 1'b0;
         r_ninf    <= 1'b0;
         r_mag     <= '0;
         r_zs      <= 1'b0;
         r_guard   <= 1'b0;
         r_sticky  <= 1'b0;
         r_exp     <= '0;
         r_z       <= 8'h00;
         r_out_z   <= 8'h00;
         r_out_stb <= 1'b0;
      end else begin
         case (r_state)
            S_ACCUM: if (input_a_stb) begin
               r_acc  <= r_acc + w_term;
               r_cnt  <= r_cnt + 1'b1;
               r_nan  <= r_nan  | w_nan;
               r_pinf <= r_pinf | w_pinf;
               r_ninf <= r_ninf | w_ninf;
            end
            S_LOAD: begin
               r_mag    <= r_acc[ACC_W-1] ? (~r_acc + 1'b1) : r_acc;
               r_zs     <= r_acc[ACC_W-1];
               r_guard  <= 1'b0;
               r_sticky <= 1'b0;
               r_exp    <= '0;
            end
            S_SHIFT: if (r_mag >= ACC_W'(32)) begin
               r_mag    <= r_mag >> 1;
               r_guard  <= r_mag[0];
               r_sticky <= r_sticky | r_guard;
               r_exp    <= r_exp + 1'b1;
            end
            // Rounding carry out of the 5-bit significand renormalises to 16 with one more exponent.
            S_ROUND: begin
               if (w_rnd == 6'd32) begin
                  r_mag <= ACC_W'(16);
                  r_exp <= w_exp_n + 1'b1;
               end else begin
                  r_mag <= ACC_W'(w_rnd);
                  r_exp <= w_exp_n;
               end
            end
            S_PACK: r_z <= w_pack;
            S_PUT: begin
               r_out_z   <= r_z;
               r_out_stb <= 1'b1;
            end
            S_CLEAR: begin
               r_out_stb <= 1'b0;
               r_acc     <= '0;
               r_cnt     <= '0;
               r_nan     <= 1'b0;
               r_pinf    <= 1'b0;
               r_ninf    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign output_z     = r_out_z;
   assign output_z_stb = r_out_stb;
endmodule

// File: tb/tb_fp8_accumulator.sv
// tb/tb_fp8_accumulator.sv - randomized bench for fp8_accumulator against an exact-arithmetic model
module tb_fp8_accumulator;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] input_a = 8'h00;
   logic       input_a_stb = 1'b0;
   logic       input_ready;
   logic [7:0] output_z;
   logic       output_z_stb;

   fp8_accumulator #(.N_TERMS(N)) dut (
      .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb),
      .input_ready(input_ready), .output_z(output_z), .output_z_stb(output_z_stb)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [7:0] z; int due; } exp_t;
   exp_t exq[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Value of a non-negative code in units of 2^-6; 0x70 stands for 16.0, the first unrepresentable step.
   function automatic int code_val(input int c);
      int e, m;
      e = (c >> 4) & 7;
      m = c & 15;
      if (e == 0) return m;
      if (e == 7) return 1024;
      return (16 + m) * (1 << (e - 1));
   endfunction

   function automatic logic [7:0] model(input logic [7:0] t [N], output int s_cnt);
      int sum, mag, best, bestd, d, e, m, v;
      bit nan, pinf, ninf;
      sum = 0; nan = 0; pinf = 0; ninf = 0;
      for (int i = 0; i < N; i++) begin
         e = int'(t[i][6:4]);
         m = int'(t[i][3:0]);
         if (e == 7) begin
            if (m != 0) nan = 1;
            else if (t[i][7]) ninf = 1;
            else pinf = 1;
         end else begin
            v = code_val(int'(t[i][6:0]));
            sum += t[i][7] ? -v : v;
         end
      end
      mag = (sum < 0) ? -sum : sum;
      s_cnt = ($clog2(mag + 1) > 5) ? $clog2(mag + 1) - 5 : 0;
      if (nan || (pinf && ninf)) return 8'hF8;
      if (pinf) return 8'h70;
      if (ninf) return 8'hF0;
      if (sum == 0) return 8'h00;
      best = 0;
      bestd = 1 << 30;
      for (int c = 0; c <= 8'h70; c++) begin
         d = mag - code_val(c);
         if (d < 0) d = -d;
         if (d < bestd || (d == bestd && (c % 2) == 0)) begin
            best = c;
            bestd = d;
         end
      end
      return {sum < 0, best[6:0]};
   endfunction

   logic [7:0] last_z = 8'h00;
   bit prev_stb = 0;
   int ready_due = -1;
   exp_t cur;

   always @(negedge clk) begin
      if (rst) begin
         last_z = 8'h00;
         prev_stb = 0;
      end else begin
         if (output_z_stb) begin
            if (exq.size() == 0) begin
               chk("unexpected_stb", 1, 0);
            end else begin
               cur = exq.pop_front();
               chk("result_z", int'(output_z), int'(cur.z));
               chk("result_latency", cyc, cur.due);
               chk("ready_low_at_stb", int'(input_ready), 0);
               last_z = cur.z;
               ready_due = cyc + 1;
            end
            if (prev_stb) chk("stb_single_pulse", 1, 0);
         end else begin
            chk("z_hold", int'(output_z), int'(last_z));
            if (cyc == ready_due) chk("ready_after_put", int'(input_ready), 1);
         end
         prev_stb = output_z_stb;
      end
   end

   task automatic send_term(input logic [7:0] b, input bit hold);
      int n = 0;
      while (input_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout: input_ready stayed low for %0d cycles, required high", n);
      end
      input_a = b;
      input_a_stb = 1'b1;
      @(posedge clk); #1;
      if (!hold) input_a_stb = 1'b0;
   endtask

   task automatic send_group(input logic [7:0] t [N], input bit extras);
      logic [7:0] z;
      int s, n;
      bit hold;
      exp_t x;
      z = model(t, s);
      for (int i = 0; i < N; i++) begin
         hold = (i < N - 1) && ($urandom_range(0, 1) == 1);
         send_term(t[i], hold);
         if (i == N - 1) begin
            x.z = z;
            x.due = cyc + 5 + s;
            exq.push_back(x);
         end else if (!hold) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
      end
      if (extras) begin
         n = 0;
         while (input_ready !== 1'b1 && n < 100) begin
            input_a = 8'($urandom);
            input_a_stb = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
         end
         input_a_stb = 1'b0;
      end
   endtask

   task automatic pin_model(input logic [7:0] t [N], input logic [7:0] z_lit, input int s_lit);
      int s;
      logic [7:0] z;
      z = model(t, s);
      chk("model_z", int'(z), int'(z_lit));
      if (s_lit >= 0) chk("model_shift", s, s_lit);
   endtask

   logic [7:0] dir_t [11][N];
   logic [7:0] dir_z [11];
   int         dir_s [11];
   logic [7:0] g [N];

   initial begin
      dir_t = '{'{8'h30, 8'h30, 8'h30, 8'h30}, '{8'h30, 8'hB0, 8'h00, 8'h00},
                '{8'h01, 8'h01, 8'h01, 8'h01}, '{8'h5F, 8'h48, 8'h00, 8'h00},
                '{8'h58, 8'h01, 8'h00, 8'h00}, '{8'h6F, 8'h6F, 8'h6F, 8'h6F},
                '{8'h70, 8'hF0, 8'h30, 8'h30}, '{8'hF0, 8'h30, 8'h30, 8'h30},
                '{8'h30, 8'h79, 8'h30, 8'h30}, '{8'h30, 8'h30, 8'h30, 8'h30},
                '{8'hB0, 8'hB0, 8'h00, 8'h00}};
      dir_z = '{8'h50, 8'h00, 8'h04, 8'h66, 8'h58, 8'h70, 8'hF8, 8'hF0, 8'hF8, 8'h50, 8'hC0};
      dir_s = '{4, -1, 0, 5, 4, 7, -1, -1, -1, 4, 3};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_z", int'(output_z), 0);
      chk("reset_stb", int'(output_z_stb), 0);
      chk("reset_ready", int'(input_ready), 1);
      @(posedge clk); #1;

      for (int k = 0; k < 11; k++) begin
         g = dir_t[k];
         pin_model(g, dir_z[k], dir_s[k]);
         send_group(g, 1'b0);
      end

      send_term(8'h30, 1'b0);
      send_term(8'h30, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midgroup_reset_z", int'(output_z), 0);
      chk("midgroup_reset_ready", int'(input_ready), 1);
      @(posedge clk); #1;
      g = dir_t[0];
      send_group(g, 1'b1);

      for (int k = 0; k < 60; k++) begin
         for (int i = 0; i < N; i++) begin
            g[i] = 8'($urandom);
            if (g[i][6:4] == 3'd7 && $urandom_range(0, 9) != 0) g[i][6] = 1'b0;
         end
         send_group(g, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      for (int n = 0; n < 100 && exq.size() != 0; n++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk("drain_pending", exq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
